data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Slave-side data memory for the pipelined CPU's MEM stage. It answers load/store requests through a valid/ready request channel and a valid/ready response channel.
- Access latency is configurable, so the pipeline's stall logic can be exercised against a non-ideal memory.
- A side debug read port lets benches check result words, such as word 0, without hierarchical references.

Parameters:
- WORDS, 1024, depth in 32-bit words; byte address range is 0 .. 4*WORDS-1.
- LATENCY, 2, cycles from request accept to response valid; minimum 1.
- ADDR_W, 32, request address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  load zero-extends (LBU/LHU) when 1, else sign-extends.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  CPU consumes the response.
- resp_rdata  out  32  load result, extended; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range, or illegal size.
- dbg_addr  in  $clog2(WORDS)  word index.
- dbg_rdata  out  32  registered word at dbg_addr, one-cycle latency.

Behaviour:
- Reset (async, rst_n low):
  - FSM goes to IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, dbg_rdata=0.
  - Memory array is not cleared.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. When req_valid&&req_ready, latch request fields, load the countdown with LATENCY-1, and go to WAIT. If LATENCY==1, go straight to RESP.
  - WAIT: req_ready=0. Decrement the counter each cycle. When it reaches 0, perform the access and go to RESP.
  - RESP: resp_valid=1. Hold resp_rdata and resp_err stable until resp_valid&&resp_ready; on that cycle go to IDLE. req_ready is 0 in RESP, so there is no overlap.
- Accepted-to-valid latency is exactly LATENCY cycles. Throughput is at most one request per LATENCY+1 cycles.
- Byte order is big-endian (MIPS): byte offset 0 maps to bits [31:24].
- Store:
  - Word writes all 4 lanes.
  - Half writes lanes {off, off+1} with req_wdata[15:0].
  - Byte writes lane off with req_wdata[7:0].
  - The write commits on the WAIT-to-RESP transition, or the accept cycle when LATENCY==1.
- Load:
  - Select the lane(s), then sign- or zero-extend per req_unsigned.
  - req_unsigned is ignored for word loads.
- Errors set resp_err=1, suppress the write, and force resp_rdata=0:
  - half with addr[0]!=0;
  - word with addr[1:0]!=0;
  - size==11;
  - addr >= 4*WORDS.
- An error response still takes the full LATENCY and handshake.
- Debug port:
  - dbg_rdata is updated every cycle.
  - If the debug word is written on the same cycle, dbg_rdata shows the old value and the new value appears the next cycle.
- A request held on req_valid while req_ready=0 is not accepted. The requester must hold its fields stable; the responder ignores the fields until the accept cycle.
- Reset mid-operation: return immediately to IDLE. A pending store whose commit cycle has not occurred is dropped; no partial write.
- resp_ready asserted outside RESP is ignored.

Test Plan:
- LATENCY=2, store word 0x000012FE to addr 0, then load word from 0: resp_valid exactly 2 cycles after each accept, rdata=0x000012FE; dbg_addr=0 then gives dbg_rdata=0x000012FE (4862).
- Store byte 0x80 to addr 5, then:
  - LB from 5 -> rdata=0xFFFFFF80;
  - LBU from 5 -> 0x00000080;
  - LW from 4 -> 0x??80???? with the other lanes unchanged.
- Store half 0xBEEF to addr 2, then:
  - LH from 2 -> 0xFFFFBEEF;
  - LHU -> 0x0000BEEF;
  - LW from 0 -> upper half unchanged, lower half 0xBEEF.
- Each error case gives resp_err=1, rdata=0, and memory unchanged (verified via dbg):
  - LW at addr 6;
  - SH at addr 3;
  - size=11;
  - addr=4*WORDS.
- Backpressure: resp_ready held low 5 cycles gives resp_valid/rdata stable and req_ready=0 throughout. A second req_valid offered meanwhile is accepted only after the handshake.
- rst_n pulsed low during WAIT of a store to addr 8 (previously 0x11111111) gives outputs at their reset values immediately, and dbg of word 2 still reads 0x11111111.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data memory slave for the CPU MEM stage: valid/ready request and response channels,
// configurable access latency, big-endian byte lanes and a registered debug read port.
module data_mem_responder #(
    parameter int WORDS   = 1024,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_rdata,
    output logic                     resp_err,
    input  logic [$clog2(WORDS)-1:0] dbg_addr,
    output logic [31:0]              dbg_rdata
);

    // state   | meaning
    // ST_IDLE | ready for a request
    // ST_WAIT | counting down the access latency
    // ST_RESP | response held until the CPU takes it

    localparam int IDX_W = $clog2(WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               lat_we;
    logic [1:0]         lat_size;
    logic               lat_unsigned;
    logic [ADDR_W-1:0]  lat_addr;
    logic [31:0]        lat_wdata;

    logic [31:0]        mem [WORDS];

    logic               accept;
    logic               do_access;
    logic               a_we;
    logic [1:0]         a_size;
    logic               a_unsigned;
    logic [ADDR_W-1:0]  a_addr;
    logic [31:0]        a_wdata;
    logic               a_err;
    logic [IDX_W-1:0]   idx;
    logic [4:0]         sh;
    logic [31:0]        old_word;
    logic [31:0]        shifted;
    logic [31:0]        ld_data;
    logic [31:0]        mask;
    logic [31:0]        wd;
    logic [31:0]        merged;
    logic [31:0]        rd_next;
    logic               mem_we;

    assign accept = req_valid && req_ready;

    // With LATENCY==1 the access happens on the accept cycle, so it must use the live fields.
    assign do_access = (LATENCY == 1) ? accept : (state == ST_WAIT && cnt == '0);

    always_comb begin
        a_we       = lat_we;
        a_size     = lat_size;
        a_unsigned = lat_unsigned;
        a_addr     = lat_addr;
        a_wdata    = lat_wdata;
        if (state == ST_IDLE) begin
            a_we       = req_we;
            a_size     = req_size;
            a_unsigned = req_unsigned;
            a_addr     = req_addr;
            a_wdata    = req_wdata;
        end
    end

    assign a_err = (a_size == 2'b11)
                || (a_size == 2'b01 && a_addr[0])
                || (a_size == 2'b10 && a_addr[1:0] != 2'b00)
                || (a_addr[ADDR_W-1:2] >= (ADDR_W-2)'(WORDS));

    assign idx      = a_addr[IDX_W+1:2];
    assign sh       = {a_addr[1:0], 3'b000};
    assign old_word = mem[idx];
    // Big-endian: shifting left by the byte offset brings the addressed lane to the top.
    assign shifted  = old_word << sh;

    always_comb begin
        ld_data = old_word;
        mask    = 32'hFFFF_FFFF;
        wd      = a_wdata;
        case (a_size)
            2'b00: begin
                ld_data = a_unsigned ? {24'b0, shifted[31:24]} : {{24{shifted[31]}}, shifted[31:24]};
                mask    = 32'hFF00_0000 >> sh;
                wd      = {a_wdata[7:0], 24'b0} >> sh;
            end
            2'b01: begin
                ld_data = a_unsigned ? {16'b0, shifted[31:16]} : {{16{shifted[31]}}, shifted[31:16]};
                mask    = 32'hFFFF_0000 >> sh;
                wd      = {a_wdata[15:0], 16'b0} >> sh;
            end
            default: ;
        endcase
    end

    assign merged  = (old_word & ~mask) | (wd & mask);
    assign rd_next = (a_err || a_we) ? 32'b0 : ld_data;
    assign mem_we  = do_access && a_we && !a_err && rst_n;

    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= merged;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'b0;
            resp_err     <= 1'b0;
            dbg_rdata    <= 32'b0;
            lat_we       <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= 32'b0;
        end else begin
            dbg_rdata <= mem[dbg_addr];
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_we       <= req_we;
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_addr     <= req_addr;
                        lat_wdata    <= req_wdata;
                        cnt          <= CNT_W'(LATENCY - 1);
                        req_ready    <= 1'b0;
                        if (LATENCY == 1) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= rd_next;
                            resp_err   <= a_err;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= rd_next;
                        resp_err   <= a_err;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: stores/loads of each size, error cases,
// response backpressure and reset during a pending store.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [9:0]  dbg_addr;
    logic [31:0] dbg_rdata;

    int n_checks = 0;
    int n_errors = 0;

    data_mem_responder #(.WORDS(1024), .LATENCY(2), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_resp(input string tag);
        int lat;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd2);
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic xfer(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
        int guard;
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp(tag);
        check({tag, " rdata"}, resp_rdata, exp_rdata);
        check({tag, " err"}, 32'(resp_err), 32'(exp_err));
        handshake();
    endtask

    task automatic dbg_chk(input string tag, input logic [9:0] idx, input logic [31:0] exp);
        dbg_addr = idx;
        @(posedge clk); #1;
        check(tag, dbg_rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0; dbg_addr = 10'd0;
        #23;
        check("rst req_ready",  32'(req_ready),  32'd1);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst resp_rdata", resp_rdata,      32'd0);
        check("rst resp_err",   32'(resp_err),   32'd0);
        check("rst dbg_rdata",  dbg_rdata,       32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        xfer("sw 0",  1'b1, 2'b10, 1'b0, 32'd0, 32'h0000_12FE, 32'h0, 1'b0);
        xfer("lw 0",  1'b0, 2'b10, 1'b0, 32'd0, 32'h0,         32'h0000_12FE, 1'b0);
        dbg_chk("dbg w0", 10'd0, 32'h0000_12FE);

        xfer("sw 4",  1'b1, 2'b10, 1'b0, 32'd4, 32'h1122_3344, 32'h0, 1'b0);
        xfer("sb 5",  1'b1, 2'b00, 1'b0, 32'd5, 32'h1234_5680, 32'h0, 1'b0);
        xfer("lb 5",  1'b0, 2'b00, 1'b0, 32'd5, 32'h0,         32'hFFFF_FF80, 1'b0);
        xfer("lbu 5", 1'b0, 2'b00, 1'b1, 32'd5, 32'h0,         32'h0000_0080, 1'b0);
        xfer("lw 4",  1'b0, 2'b10, 1'b0, 32'd4, 32'h0,         32'h1180_3344, 1'b0);

        xfer("sh 2",  1'b1, 2'b01, 1'b0, 32'd2, 32'hAAAA_BEEF, 32'h0, 1'b0);
        xfer("lh 2",  1'b0, 2'b01, 1'b0, 32'd2, 32'h0,         32'hFFFF_BEEF, 1'b0);
        xfer("lhu 2", 1'b0, 2'b01, 1'b1, 32'd2, 32'h0,         32'h0000_BEEF, 1'b0);
        xfer("lw 0b", 1'b0, 2'b10, 1'b0, 32'd0, 32'h0,         32'h0000_BEEF, 1'b0);
        xfer("lb 3",  1'b0, 2'b00, 1'b0, 32'd3, 32'h0,         32'hFFFF_FFEF, 1'b0);
        xfer("lhu 4", 1'b0, 2'b01, 1'b1, 32'd4, 32'h0,         32'h0000_1180, 1'b0);

        xfer("err lw 6",   1'b0, 2'b10, 1'b0, 32'd6,    32'h0,         32'h0, 1'b1);
        xfer("err sh 3",   1'b1, 2'b01, 1'b0, 32'd3,    32'h0000_1234, 32'h0, 1'b1);
        dbg_chk("dbg w0 after sh 3", 10'd0, 32'h0000_BEEF);
        xfer("err size11", 1'b1, 2'b11, 1'b0, 32'd4,    32'h0,         32'h0, 1'b1);
        dbg_chk("dbg w1 after size11", 10'd1, 32'h1180_3344);
        xfer("err range",  1'b1, 2'b10, 1'b0, 32'd4096, 32'hDEAD_BEEF, 32'h0, 1'b1);
        dbg_chk("dbg w0 after range", 10'd0, 32'h0000_BEEF);
        xfer("err range ld", 1'b0, 2'b10, 1'b0, 32'd4100, 32'h0,       32'h0, 1'b1);

        // Backpressure: second request waits on req_valid while the first response is stalled.
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'd4; req_wdata = 32'd0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_addr = 32'd0;
        wait_resp("bp first");
        for (int i = 0; i < 5; i++) begin
            check("bp resp_valid", 32'(resp_valid), 32'd1);
            check("bp rdata",      resp_rdata,      32'h1180_3344);
            check("bp req_ready",  32'(req_ready),  32'd0);
            @(posedge clk); #1;
        end
        handshake();
        check("bp after hs req_ready",  32'(req_ready),  32'd1);
        check("bp after hs resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp("bp second");
        check("bp second rdata", resp_rdata, 32'h0000_BEEF);
        handshake();

        // Reset while a store sits in WAIT must drop the store.
        xfer("sw 8",  1'b1, 2'b10, 1'b0, 32'd8, 32'h1111_1111, 32'h0, 1'b0);
        xfer("lw 8",  1'b0, 2'b10, 1'b0, 32'd8, 32'h0,         32'h1111_1111, 1'b0);
        req_we = 1'b1; req_size = 2'b10; req_addr = 32'd8; req_wdata = 32'h2222_2222;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("mid pre-rst req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid rst req_ready",  32'(req_ready),  32'd1);
        check("mid rst resp_valid", 32'(resp_valid), 32'd0);
        check("mid rst resp_rdata", resp_rdata,      32'd0);
        check("mid rst resp_err",   32'(resp_err),   32'd0);
        check("mid rst dbg_rdata",  dbg_rdata,       32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        dbg_chk("dbg w2 after rst", 10'd2, 32'h1111_1111);
        xfer("lw 8 after rst", 1'b0, 2'b10, 1'b0, 32'd8, 32'h0, 32'h1111_1111, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
